// File: rtl/wishbone_arbiter_2m_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// State encodings double as the one-hot grant vector {m1,m0}.
package wishbone_arbiter_2m_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_GNT0 = 2'b01,
      ARB_GNT1 = 2'b10
   } arb_state_e;

   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic        RST_ENABLE    = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        we;
      logic [3:0]  sel;
      logic        stb;
      logic        cyc;
   } wb_req_t;

   localparam wb_req_t REQ_IDLE = '{addr: ZERO_WORD, data: ZERO_WORD, we: WRITE_DISABLE,
                                    sel: 4'h0, stb: 1'b0, cyc: 1'b0};

endpackage

// File: rtl/wb_bus_watchdog.sv
// Counts strobe cycles without an ack and flags expiry on the TIMEOUT-th one.
// Combinational expire from registered count; ack in the same cycle suppresses it.
module wb_bus_watchdog
   import wishbone_arbiter_2m_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int TMO_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   input  logic ack,
   output logic expire
);

   localparam logic [TMO_W-1:0] LAST_CNT = TMO_W'(TIMEOUT - 1);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   assign expire = run & ~ack & (cnt_q == LAST_CNT);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || ack || expire) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wishbone_arbiter_2m.sv
// Two-master Wishbone arbiter: registered per-cycle grant, combinational muxes,
// watchdog abort on a silent slave. Response path adds no latency.
module wishbone_arbiter_2m
   import wishbone_arbiter_2m_pkg::*;
#(
   parameter bit RR_EN   = 1'b0,
   parameter int TIMEOUT = 255,
   parameter int TMO_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_data_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic [31:0] m0_data_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_data_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic [31:0] m1_data_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_data_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic [31:0] s_data_i,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o
);

   arb_state_e state_q, state_d;
   logic       last_q, last_d;   // 1: m1 was granted most recently
   wb_req_t    m0_req, m1_req, own_req;
   logic       own_ack, abort, wd_clr;

   assign m0_req = '{addr: m0_addr_i, data: m0_data_i, we: m0_we_i,
                     sel: m0_sel_i, stb: m0_stb_i, cyc: m0_cyc_i};
   assign m1_req = '{addr: m1_addr_i, data: m1_data_i, we: m1_we_i,
                     sel: m1_sel_i, stb: m1_stb_i, cyc: m1_cyc_i};

   always_comb begin
      own_req = REQ_IDLE;
      case (state_q)
         ARB_GNT0: own_req = m0_req;
         ARB_GNT1: own_req = m1_req;
         default:  own_req = REQ_IDLE;
      endcase
   end

   // Re-arbitrate only when idle or when the owner has released cyc.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      if (state_q == ARB_IDLE || !own_req.cyc) begin
         if (m0_cyc_i && m1_cyc_i) begin
            state_d = (RR_EN && !last_q) ? ARB_GNT1 : ARB_GNT0;
         end else if (m0_cyc_i) begin
            state_d = ARB_GNT0;
         end else if (m1_cyc_i) begin
            state_d = ARB_GNT1;
         end else begin
            state_d = ARB_IDLE;
         end
         if (state_d != ARB_IDLE) begin
            last_d = (state_d == ARB_GNT1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q <= ARB_IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Acks only count against a live strobe; stray acks never reach a master.
   assign own_ack = s_ack_i & own_req.stb;
   assign wd_clr  = (state_q == ARB_IDLE) || (state_d != state_q);

   wb_bus_watchdog #(
      .TIMEOUT (TIMEOUT),
      .TMO_W   (TMO_W)
   ) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (wd_clr),
      .run    (own_req.stb),
      .ack    (own_ack),
      .expire (abort)
   );

   assign s_addr_o = own_req.addr;
   assign s_data_o = own_req.data;
   assign s_we_o   = own_req.we;
   assign s_sel_o  = own_req.sel;
   assign s_stb_o  = own_req.stb & ~abort;
   assign s_cyc_o  = own_req.cyc;
   assign gnt_o    = state_q;

   assign m0_data_o = (state_q == ARB_GNT0) ? s_data_i : ZERO_WORD;
   assign m0_ack_o  = (state_q == ARB_GNT0) & own_ack;
   assign m0_err_o  = (state_q == ARB_GNT0) & abort;
   assign m1_data_o = (state_q == ARB_GNT1) ? s_data_i : ZERO_WORD;
   assign m1_ack_o  = (state_q == ARB_GNT1) & own_ack;
   assign m1_err_o  = (state_q == ARB_GNT1) & abort;

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Bench for wishbone_arbiter_2m: instance 0 fixed priority, instance 1 round-robin,
// both with a 4-cycle watchdog and driven by the same master/slave stimulus.
module tb_wishbone_arbiter_2m;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat, s_rdat;
   logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;
   logic [3:0]  m0_sel, m1_sel;

   logic [31:0]  o_m0_data [2], o_m1_data [2], o_s_addr [2], o_s_data [2];
   logic         o_m0_ack [2], o_m0_err [2], o_m1_ack [2], o_m1_err [2];
   logic         o_s_we [2], o_s_stb [2], o_s_cyc [2];
   logic [3:0]   o_s_sel [2];
   logic [1:0]   o_gnt [2];
   logic [140:0] obs [2];

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      wishbone_arbiter_2m #(.RR_EN(g == 1), .TIMEOUT(TMO), .TMO_W(3)) u_dut (
         .clk(clk), .rst(rst),
         .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
         .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
         .m0_data_o(o_m0_data[g]), .m0_ack_o(o_m0_ack[g]), .m0_err_o(o_m0_err[g]),
         .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
         .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
         .m1_data_o(o_m1_data[g]), .m1_ack_o(o_m1_ack[g]), .m1_err_o(o_m1_err[g]),
         .s_addr_o(o_s_addr[g]), .s_data_o(o_s_data[g]), .s_we_o(o_s_we[g]),
         .s_sel_o(o_s_sel[g]), .s_stb_o(o_s_stb[g]), .s_cyc_o(o_s_cyc[g]),
         .s_data_i(s_rdat), .s_ack_i(s_ack), .gnt_o(o_gnt[g]));
      assign obs[g] = {o_gnt[g], o_s_addr[g], o_s_data[g], o_s_we[g], o_s_sel[g],
                       o_s_stb[g], o_s_cyc[g], o_m0_data[g], o_m0_ack[g], o_m0_err[g],
                       o_m1_data[g], o_m1_ack[g], o_m1_err[g]};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_addr = 0; m0_wdat = 0; m0_we = 0; m0_sel = 0; m0_stb = 0; m0_cyc = 0;
      m1_addr = 0; m1_wdat = 0; m1_we = 0; m1_sel = 0; m1_stb = 0; m1_cyc = 0;
      s_rdat = 0; s_ack = 0;
   endtask

   task automatic settle_idle();
      idle_inputs();
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_total++;
         if (obs[d] !== '0) $display("FAIL reset_outputs dut%0d: got %h want 0", d, obs[d]);
         else n_pass++;
      end
   endtask

   task automatic test_solo_read();
      step();
      m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100; m0_sel = 4'hF;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_total++;
         if ({o_gnt[d], o_s_stb[d]} !== 3'b000)
            $display("FAIL solo_c0_idle dut%0d: got gnt=%b stb=%b want 00/0", d, o_gnt[d], o_s_stb[d]);
         else n_pass++;
      end
      step();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_total++;
         if ({o_gnt[d], o_s_stb[d], o_s_addr[d]} !== {2'b01, 1'b1, 32'h100})
            $display("FAIL solo_c1_req dut%0d: got gnt=%b stb=%b addr=%h want 01/1/100",
                     d, o_gnt[d], o_s_stb[d], o_s_addr[d]);
         else n_pass++;
      end
      step();
      step();
      s_ack = 1; s_rdat = 32'hDEADBEEF;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_total++;
         if ({o_m0_ack[d], o_m0_err[d], o_m0_data[d]} !== {2'b10, 32'hDEADBEEF})
            $display("FAIL solo_c3_ack dut%0d: got ack=%b err=%b data=%h want 1/0/deadbeef",
                     d, o_m0_ack[d], o_m0_err[d], o_m0_data[d]);
         else n_pass++;
         n_total++;
         if ({o_m1_data[d], o_m1_ack[d], o_m1_err[d]} !== 34'h0)
            $display("FAIL solo_m1_quiet dut%0d: got %h want 0", d,
                     {o_m1_data[d], o_m1_ack[d], o_m1_err[d]});
         else n_pass++;
      end
      settle_idle();
   endtask

   task automatic test_simultaneous();
      logic [1:0] want;
      step();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
      for (int c = 1; c <= 4; c++) begin
         step();
         if (c == 3) begin m0_cyc = 0; m0_stb = 0; end
         @(negedge clk);
         want = (c < 4) ? 2'b01 : 2'b10;
         n_total++;
         if (o_gnt[0] !== want) $display("FAIL simul_fixed c%0d: got %b want %b", c, o_gnt[0], want);
         else n_pass++;
         if (c == 1) begin
            // last grant of the round-robin instance was m0, so the tie goes to m1
            n_total++;
            if (o_gnt[1] !== 2'b10) $display("FAIL simul_rr_tie: got %b want 10", o_gnt[1]);
            else n_pass++;
         end
      end
      settle_idle();
   endtask

   task automatic test_rr_alternate();
      logic [1:0] seq[$];
      logic [1:0] prev;
      logic [1:0] want;
      bit a0, a1;
      prev = 2'b00; a0 = 0; a1 = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         m0_cyc = !a0; m0_stb = !a0; m1_cyc = !a1; m1_stb = !a1; s_ack = 1;
         @(negedge clk);
         a0 = o_m0_ack[1]; a1 = o_m1_ack[1];
         if (o_gnt[1] != 2'b00 && o_gnt[1] != prev) seq.push_back(o_gnt[1]);
         if (o_gnt[1] != 2'b00) prev = o_gnt[1];
      end
      n_total++;
      if (seq.size() < 4) $display("FAIL rr_seq_len: got %0d want >=4", seq.size());
      else n_pass++;
      for (int i = 0; i < 4 && i < seq.size(); i++) begin
         want = (i % 2 == 0) ? 2'b01 : 2'b10;
         n_total++;
         if (seq[i] !== want) $display("FAIL rr_seq[%0d]: got %b want %b", i, seq[i], want);
         else n_pass++;
      end
      settle_idle();
   endtask

   task automatic test_held_cycle();
      logic [1:0] want;
      step();
      m1_cyc = 1; m1_stb = 1;
      for (int c = 1; c <= 5; c++) begin
         step();
         if (c == 1) begin m0_cyc = 1; m0_stb = 1; s_ack = 1; end
         if (c == 4) begin m1_cyc = 0; m1_stb = 0; s_ack = 0; end
         @(negedge clk);
         want = (c < 5) ? 2'b10 : 2'b01;
         for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({o_gnt[d], o_m0_ack[d]} !== {want, 1'b0})
               $display("FAIL held c%0d dut%0d: got gnt=%b m0_ack=%b want %b/0",
                        c, d, o_gnt[d], o_m0_ack[d], want);
            else n_pass++;
         end
      end
      settle_idle();
   endtask

   task automatic test_timeout();
      for (int v = 0; v < 2; v++) begin
         step();
         m0_cyc = 1; m0_stb = 1;
         for (int c = 1; c <= 4; c++) begin
            step();
            s_ack = (v == 1 && c == 4);
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
               logic [2:0] want;
               // v0: silent slave aborts on the 4th strobe; v1: ack on that cycle wins
               want = (v == 0) ? {c != 4, 1'b0, c == 4} : {1'b1, c == 4, 1'b0};
               n_total++;
               if ({o_s_stb[d], o_m0_ack[d], o_m0_err[d]} !== want)
                  $display("FAIL timeout v%0d c%0d dut%0d: got stb/ack/err=%b want %b",
                           v, c, d, {o_s_stb[d], o_m0_ack[d], o_m0_err[d]}, want);
               else n_pass++;
            end
         end
         settle_idle();
      end
   endtask

   task automatic test_reset_mid();
      step();
      m0_cyc = 1; m0_stb = 1;
      step();
      step();
      rst = 1;
      step();
      rst = 0; s_ack = 1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_total++;
         if (obs[d] !== '0) $display("FAIL rst_mid dut%0d: got %h want 0", d, obs[d]);
         else n_pass++;
      end
      for (int c = 4; c <= 7; c++) begin
         step();
         s_ack = 0;
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            n_total++;
            if (o_m0_err[d] !== (c == 7))
               $display("FAIL rst_wdog c%0d dut%0d: got err=%b want %b", c, d, o_m0_err[d], c == 7);
            else n_pass++;
         end
      end
      settle_idle();
   endtask

   task automatic test_random_vs_model();
      int own [2];
      int last [2];
      int wd [2];
      rst = 1;
      step();
      rst = 0;
      for (int d = 0; d < 2; d++) begin own[d] = -1; last[d] = 1; wd[d] = 0; end
      for (int n = 0; n < 600; n++) begin
         step();
         if ($urandom_range(5, 0) == 0) m0_cyc = ~m0_cyc;
         if ($urandom_range(5, 0) == 0) m1_cyc = ~m1_cyc;
         m0_stb = m0_cyc && ($urandom_range(3, 0) != 0);
         m1_stb = m1_cyc && ($urandom_range(3, 0) != 0);
         m0_addr = $urandom; m0_wdat = $urandom; m0_we = $urandom_range(1, 0); m0_sel = 4'($urandom);
         m1_addr = $urandom; m1_wdat = $urandom; m1_we = $urandom_range(1, 0); m1_sel = 4'($urandom);
         s_ack = ($urandom_range(4, 0) == 0);
         s_rdat = $urandom;
         rst = ($urandom_range(79, 0) == 0);
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            logic [140:0] exp;
            logic [1:0]  e_gnt;
            logic [31:0] e_addr, e_wdat, e_d0, e_d1;
            logic [3:0]  e_sel;
            logic e_we, e_stb, e_cyc, e_a0, e_e0, e_a1, e_e1, ostb, ocyc, abrt;
            int nxt;
            e_gnt = 0; e_addr = 0; e_wdat = 0; e_d0 = 0; e_d1 = 0; e_sel = 0;
            e_we = 0; e_stb = 0; e_cyc = 0; e_a0 = 0; e_e0 = 0; e_a1 = 0; e_e1 = 0;
            ostb = 0; ocyc = 0; abrt = 0;
            if (own[d] >= 0) begin
               ostb   = (own[d] == 0) ? m0_stb : m1_stb;
               ocyc   = (own[d] == 0) ? m0_cyc : m1_cyc;
               abrt   = ostb && !s_ack && (wd[d] == TMO - 1);
               e_gnt  = (own[d] == 0) ? 2'b01 : 2'b10;
               e_addr = (own[d] == 0) ? m0_addr : m1_addr;
               e_wdat = (own[d] == 0) ? m0_wdat : m1_wdat;
               e_we   = (own[d] == 0) ? m0_we : m1_we;
               e_sel  = (own[d] == 0) ? m0_sel : m1_sel;
               e_stb  = ostb && !abrt;
               e_cyc  = ocyc;
               if (own[d] == 0) begin e_d0 = s_rdat; e_a0 = s_ack && ostb; e_e0 = abrt; end
               else begin e_d1 = s_rdat; e_a1 = s_ack && ostb; e_e1 = abrt; end
            end
            exp = {e_gnt, e_addr, e_wdat, e_we, e_sel, e_stb, e_cyc,
                   e_d0, e_a0, e_e0, e_d1, e_a1, e_e1};
            n_total++;
            if (obs[d] !== exp)
               $display("FAIL random n%0d dut%0d: got %h want %h", n, d, obs[d], exp);
            else n_pass++;
            if (rst) begin
               own[d] = -1; last[d] = 1; wd[d] = 0;
            end else begin
               nxt = own[d];
               if (own[d] < 0 || !ocyc) begin
                  if (m0_cyc && m1_cyc) nxt = (d == 1) ? 1 - last[d] : 0;
                  else if (m0_cyc) nxt = 0;
                  else if (m1_cyc) nxt = 1;
                  else nxt = -1;
                  if (nxt >= 0) last[d] = nxt;
               end
               if (own[d] < 0 || nxt != own[d] || (s_ack && ostb) || abrt) wd[d] = 0;
               else if (ostb) wd[d] = wd[d] + 1;
               own[d] = nxt;
            end
         end
      end
      rst = 0;
      settle_idle();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_solo_read();
      test_simultaneous();
      test_rr_alternate();
      test_held_cycle();
      test_timeout();
      test_reset_mid();
      test_random_vs_model();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
